// File: rtl/mdu_iterative.sv
// Multi-cycle multiply/divide unit with HI/LO registers and a countdown busy counter.
// Define MDU_MADD_EN to enable the accumulate ops MADD/MADDU/MSUB/MSUBU (op 7-10).
module mdu_iterative #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] v1,
    input  logic [WIDTH-1:0] v2,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int W2 = 2 * WIDTH;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] W_ONE    = WIDTH'(1);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_pend_hi;
    logic [WIDTH-1:0] r_pend_lo;
    logic [CNT_W-1:0] r_cnt;

    logic             w_is_signed;
    logic [W2-1:0]    w_ext1;
    logic [W2-1:0]    w_ext2;
    logic [W2-1:0]    w_prod;

    assign w_is_signed = (op == OP_MULT) || (op == OP_DIV) ||
                         (op == OP_MADD) || (op == OP_MSUB);

    // Sign/zero extension to 2*WIDTH lets one truncated multiplier serve both signednesses.
    assign w_ext1[WIDTH-1:0] = v1;
    assign w_ext2[WIDTH-1:0] = v2;
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ext
            assign w_ext1[WIDTH+gi] = w_is_signed & v1[WIDTH-1];
            assign w_ext2[WIDTH+gi] = w_is_signed & v2[WIDTH-1];
        end
    endgenerate

    assign w_prod = w_ext1 * w_ext2;

    logic             w_v1_neg;
    logic             w_v2_neg;
    logic             w_div_zero;
    logic [WIDTH-1:0] w_v1_mag;
    logic [WIDTH-1:0] w_v2_mag;
    logic [WIDTH-1:0] w_v2_safe;
    logic [WIDTH-1:0] w_q_mag;
    logic [WIDTH-1:0] w_r_mag;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    // Divide on magnitudes, then re-apply signs: truncation toward zero, remainder
    // follows the dividend. MIN / -1 naturally yields quotient MIN, remainder 0.
    assign w_v1_neg   = w_is_signed & v1[WIDTH-1];
    assign w_v2_neg   = w_is_signed & v2[WIDTH-1];
    assign w_v1_mag   = w_v1_neg ? -v1 : v1;
    assign w_v2_mag   = w_v2_neg ? -v2 : v2;
    assign w_div_zero = (v2 == '0);
    assign w_v2_safe  = w_div_zero ? W_ONE : w_v2_mag;
    assign w_q_mag    = w_v1_mag / w_v2_safe;
    assign w_r_mag    = w_v1_mag % w_v2_safe;
    assign w_quot     = (w_v1_neg ^ w_v2_neg) ? -w_q_mag : w_q_mag;
    assign w_rem      = w_v1_neg ? -w_r_mag : w_r_mag;

`ifdef MDU_MADD_EN
    logic [W2-1:0] w_acc_add;
    logic [W2-1:0] w_acc_sub;
    assign w_acc_add = {r_hi, r_lo} + w_prod;
    assign w_acc_sub = {r_hi, r_lo} - w_prod;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_cnt     <= '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end else if (start) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    {r_pend_hi, r_pend_lo} <= w_prod;
                    r_cnt                  <= MULT_CNT;
                end
                OP_DIV, OP_DIVU: begin
                    // Divide by zero commits the current HI/LO back, i.e. no change.
                    if (w_div_zero) begin
                        r_pend_hi <= r_hi;
                        r_pend_lo <= r_lo;
                    end else begin
                        r_pend_hi <= w_rem;
                        r_pend_lo <= w_quot;
                    end
                    r_cnt <= DIV_CNT;
                end
                OP_MTHI: r_hi <= v1;
                OP_MTLO: r_lo <= v1;
`ifdef MDU_MADD_EN
                OP_MADD, OP_MADDU: begin
                    {r_pend_hi, r_pend_lo} <= w_acc_add;
                    r_cnt                  <= MULT_CNT;
                end
                OP_MSUB, OP_MSUBU: begin
                    {r_pend_hi, r_pend_lo} <= w_acc_sub;
                    r_cnt                  <= MULT_CNT;
                end
`endif
                default: ;
            endcase
        end
    end

    assign busy = (r_cnt != '0);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative (default parameters, WIDTH=32).
module tb_mdu_iterative;
    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;
    int nb;

    mdu_iterative dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .v1    (v1),
        .v2    (v2),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Issue one op and count busy cycles (bounded); returns at first non-busy negedge.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        @(negedge clk);
        start = 1'b1; op = o; v1 = a; v2 = b;
        @(negedge clk);
        start = 1'b0; op = 4'd0; v1 = 32'h5A5A_5A5A; v2 = 32'hA5A5_A5A5;
        cycles = 0;
        while (busy && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 4'd0; v1 = '0; v2 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, nb);
        check("mult_busy_cycles", 64'(nb), 64'd5);
        check("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        check("mult_lo", {32'd0, lo}, 64'hFFFF_FFFA);

        run_op(4'd2, 32'hFFFF_FFFF, 32'd2, nb);
        check("multu_hi", {32'd0, hi}, 64'h1);
        check("multu_lo", {32'd0, lo}, 64'hFFFF_FFFE);

        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, nb);
        check("div_busy_cycles", 64'(nb), 64'd10);
        check("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        check("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);

        run_op(4'd5, 32'h11, 32'd0, nb);
        check("mthi_busy_cycles", 64'(nb), 64'd0);
        check("mthi_hi", {32'd0, hi}, 64'h11);
        run_op(4'd6, 32'h22, 32'd0, nb);
        check("mtlo_lo", {32'd0, lo}, 64'h22);

        run_op(4'd4, 32'd1234, 32'd0, nb);
        check("div0_busy_cycles", 64'(nb), 64'd10);
        check("div0_hi", {32'd0, hi}, 64'h11);
        check("div0_lo", {32'd0, lo}, 64'h22);

        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, nb);
        check("divovf_lo", {32'd0, lo}, 64'h8000_0000);
        check("divovf_hi", {32'd0, hi}, 64'h0);

        run_op(4'd4, 32'd100, 32'd7, nb);
        check("divu_lo", {32'd0, lo}, 64'd14);
        check("divu_hi", {32'd0, hi}, 64'd2);

        run_op(4'd5, 32'hABCD, 32'd0, nb);
        check("mthi2_busy_cycles", 64'(nb), 64'd0);
        check("mthi2_hi", {32'd0, hi}, 64'hABCD);

        // start held high through the whole busy window, including the commit edge
        @(negedge clk);
        start = 1'b1; op = 4'd1; v1 = 32'd3; v2 = 32'd4;
        @(negedge clk);
        op = 4'd6; v1 = 32'hDEAD;
        nb = 0;
        while (busy && nb < 40) begin
            nb++;
            @(negedge clk);
        end
        start = 1'b0; op = 4'd0;
        check("busy_start_cycles", 64'(nb), 64'd5);
        @(negedge clk);
        check("busy_start_hi", {32'd0, hi}, 64'd0);
        check("busy_start_lo", {32'd0, lo}, 64'd12);
        check("busy_start_idle", {63'd0, busy}, 64'd0);

        run_op(4'd12, 32'd7, 32'd7, nb);
        check("op12_busy_cycles", 64'(nb), 64'd0);
        check("op12_lo", {32'd0, lo}, 64'd12);

        // reset during the third busy cycle of a DIV
        run_op(4'd5, 32'h77, 32'd0, nb);
        @(negedge clk);
        start = 1'b1; op = 4'd3; v1 = 32'd100; v2 = 32'd7;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        repeat (12) @(negedge clk);
        check("abort_late_hi", {32'd0, hi}, 64'd0);
        check("abort_late_lo", {32'd0, lo}, 64'd0);

`ifdef MDU_MADD_EN
        run_op(4'd5, 32'h0, 32'd0, nb);
        run_op(4'd6, 32'hFFFF_FFFF, 32'd0, nb);
        run_op(4'd8, 32'd1, 32'd1, nb);
        check("maddu_busy_cycles", 64'(nb), 64'd5);
        check("maddu_hi", {32'd0, hi}, 64'h1);
        check("maddu_lo", {32'd0, lo}, 64'h0);
        run_op(4'd5, 32'h0, 32'd0, nb);
        run_op(4'd9, 32'd1, 32'd1, nb);
        check("msub_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        check("msub_lo", {32'd0, lo}, 64'hFFFF_FFFF);
`else
        run_op(4'd5, 32'h5, 32'd0, nb);
        run_op(4'd6, 32'h6, 32'd0, nb);
        run_op(4'd7, 32'd3, 32'd3, nb);
        check("madd_off_busy_cycles", 64'(nb), 64'd0);
        check("madd_off_hi", {32'd0, hi}, 64'h5);
        check("madd_off_lo", {32'd0, lo}, 64'h6);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
